// File: rtl/daisychain_pkg.sv
// Shared types and sizing helpers for the daisy-chain sequencer.
// DATA_LEN sets the default chain length when the build does not provide it.
`ifndef DATA_LEN
`define DATA_LEN 8
`endif

package daisychain_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } ctrl_state_e;

  localparam int DEFAULT_CHAIN_LEN = `DATA_LEN;

  // Width that can hold 0..max_val inclusive, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int bit_cnt_width(input int chain_len);
    return cnt_width(chain_len);
  endfunction

  function automatic int div_cnt_width(input int shift_div);
    return cnt_width(shift_div);
  endfunction

endpackage

// File: rtl/daisychain_pacer.sv
// Shift-strobe divider: while run is high, strobe fires once every SHIFT_DIV
// cycles, starting SHIFT_DIV-1 cycles after the last clear.
module daisychain_pacer
  import daisychain_pkg::*;
#(
  parameter int SHIFT_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic strobe
);

  localparam int DW = div_cnt_width(SHIFT_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SHIFT_DIV - 1);

  logic [DW-1:0] div_cnt;

  assign strobe = run & (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (run) begin
      // Restart at the terminal value so the count never wraps.
      if (strobe) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/daisychain_ctrl.sv
// Daisy-chain sequencer: serialises a command word LSB-first, then pulses update.
// Optional feature macro: DAISYCHAIN_READBACK_EN (captures old chain contents).
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// cmd_ready is high only in IDLE, and cmd_data is ignored at all other times.
module daisychain_ctrl
  import daisychain_pkg::*;
#(
  parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
  parameter int SHIFT_DIV = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CHAIN_LEN-1:0] cmd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 chain_data_in,
  output logic                 chain_enable,
  output logic                 chain_update,
  input  logic                 chain_data_out,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output ctrl_state_e          dbg_state
);

  localparam int BW = bit_cnt_width(CHAIN_LEN);
  localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);

  ctrl_state_e          state;
  logic [CHAIN_LEN-1:0] shadow;
  logic [BW-1:0]        bit_cnt;
  logic                 accept;
  logic                 shifting;
  logic                 strobe;

  assign accept    = cmd_valid & cmd_ready;
  assign shifting  = (state == SHIFT);
  assign dbg_state = state;

  daisychain_pacer #(
    .SHIFT_DIV (SHIFT_DIV)
  ) u_pacer (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .run    (shifting),
    .strobe (strobe)
  );

  // Serial data and strobe are decoded from registered state, so they are
  // stable for the whole cycle the chain samples them.
  assign chain_enable  = shifting & strobe;
  assign chain_data_in = shifting & shadow[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      shadow       <= '0;
      bit_cnt      <= '0;
      cmd_ready    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      chain_update <= 1'b0;
    end else begin
      done         <= 1'b0;
      chain_update <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shadow    <= cmd_data;
            bit_cnt   <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        SHIFT: begin
          if (chain_enable) begin
            shadow  <= shadow >> 1;
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) begin
              done         <= 1'b1;
              chain_update <= 1'b1;
              state        <= UPDATE;
            end
          end
        end
        UPDATE: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef DAISYCHAIN_READBACK_EN
  logic [CHAIN_LEN-1:0] rsp_q;

  // Old cell 0 leaves the chain first, so after CHAIN_LEN strobes old cell i
  // sits in rsp_q[i].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_q <= '0;
    end else if (chain_enable) begin
      rsp_q <= {chain_data_out, rsp_q[CHAIN_LEN-1:1]};
    end
  end

  assign rsp_data = rsp_q;
`else
  logic unused_chain_data_out;

  assign unused_chain_data_out = chain_data_out;
  assign rsp_data = '0;
`endif

endmodule

// File: tb/tb_daisychain_ctrl.sv
// Directed bench for daisychain_ctrl with behavioural shift-register chains.
module tb_daisychain_ctrl;
  import daisychain_pkg::*;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int overlap  = 0;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: SHIFT_DIV=1, DUT B: SHIFT_DIV=3
  logic       va = 1'b0, vb = 1'b0;
  logic [7:0] da = '0, db = '0;
  logic       rdy_a, busy_a, done_a, din_a, en_a, upd_a, dout_a;
  logic       rdy_b, busy_b, done_b, din_b, en_b, upd_b, dout_b;
  logic [7:0] rsp_a, rsp_b;
  ctrl_state_e st_a, st_b;

  daisychain_ctrl #(.CHAIN_LEN(8), .SHIFT_DIV(1)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(va), .cmd_ready(rdy_a), .cmd_data(da),
    .busy(busy_a), .done(done_a), .chain_data_in(din_a), .chain_enable(en_a),
    .chain_update(upd_a), .chain_data_out(dout_a), .rsp_data(rsp_a), .dbg_state(st_a)
  );

  daisychain_ctrl #(.CHAIN_LEN(8), .SHIFT_DIV(3)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(vb), .cmd_ready(rdy_b), .cmd_data(db),
    .busy(busy_b), .done(done_b), .chain_data_in(din_b), .chain_enable(en_b),
    .chain_update(upd_b), .chain_data_out(dout_b), .rsp_data(rsp_b), .dbg_state(st_b)
  );

  // Chains: data enters the top cell and leaves from cell 0; not reset by the controller.
  logic [7:0] cells_a = '0, bout_a = '0, cells_b = '0, bout_b = '0;
  assign dout_a = cells_a[0];
  assign dout_b = cells_b[0];
  always @(posedge clk) begin
    if (en_a) cells_a <= {din_a, cells_a[7:1]};
    if (upd_a) bout_a <= cells_a;
    if (en_b) cells_b <= {din_b, cells_b[7:1]};
    if (upd_b) bout_b <= cells_b;
  end

  // Monitor
  int         en_cyc_a[$], done_cyc_a[$], en_cyc_b[$], done_cyc_b[$];
  logic       din_q_a[$], din_q_b[$];
  logic [7:0] rsp_done_a = '0;
  always @(negedge clk) begin
    if (en_a) begin en_cyc_a.push_back(cyc); din_q_a.push_back(din_a); end
    if (done_a) begin done_cyc_a.push_back(cyc); rsp_done_a = rsp_a; end
    if (en_b) begin en_cyc_b.push_back(cyc); din_q_b.push_back(din_b); end
    if (done_b) done_cyc_b.push_back(cyc);
    if ((en_a && upd_a) || (en_b && upd_b)) overlap++;
  end

  // Scoreboard expected serial bits
  logic [0:0] exp_q[$];

  task automatic clear_logs();
    en_cyc_a.delete(); done_cyc_a.delete(); din_q_a.delete();
    en_cyc_b.delete(); done_cyc_b.delete(); din_q_b.delete();
  endtask

  function automatic logic [7:0] pack_bits(input bit sel_b);
    logic [7:0] v;
    v = '0;
    if (sel_b) begin
      for (int i = 0; i < din_q_b.size() && i < 8; i++) v[i] = din_q_b[i];
    end else begin
      for (int i = 0; i < din_q_a.size() && i < 8; i++) v[i] = din_q_a[i];
    end
    return v;
  endfunction

  // Driver: call at a negedge; returns at the negedge after acceptance.
  task automatic issue(input bit sel_b, input logic [7:0] d, output int t_acc);
    int n;
    n = 0;
    if (sel_b) begin vb = 1'b1; db = d; end
    else begin va = 1'b1; da = d; end
    while (((sel_b ? rdy_b : rdy_a) !== 1'b1) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 60) begin
      failures++;
      $display("FAIL issue_timeout: cmd_ready stayed low for %0d cycles, required 1", n);
    end
    t_acc = cyc;
    @(negedge clk);
    va = 1'b0;
    vb = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({rdy_a, busy_a, done_a, din_a, en_a, upd_a} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 000000",
               {rdy_a, busy_a, done_a, din_a, en_a, upd_a});
    end
    checks++;
    if (rsp_a !== 8'h00 || st_a !== IDLE) begin
      failures++;
      $display("FAIL reset_rsp_state: rsp=%h state=%0d required 00/IDLE", rsp_a, st_a);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got a=%b b=%b required 1", rdy_a, rdy_b);
    end
  endtask

  task automatic test_basic();
    int t;
    logic [7:0] w;
    w = 8'hA5;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
    clear_logs();
    issue(1'b0, 8'hA5, t);
    repeat (10) @(negedge clk);
    checks++;
    if (en_cyc_a.size() !== 8) begin
      failures++;
      $display("FAIL basic_strobes: got %0d required 8", en_cyc_a.size());
    end
    if (en_cyc_a.size() == 8) begin
      checks++;
      if (en_cyc_a[0] !== t + 1 || en_cyc_a[7] !== t + 8) begin
        failures++;
        $display("FAIL basic_strobe_cycles: got %0d..%0d required %0d..%0d",
                 en_cyc_a[0], en_cyc_a[7], t + 1, t + 8);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (din_q_a[i] !== exp_q[i][0]) begin
          failures++;
          $display("FAIL basic_serial_bit%0d: got %b required %b", i, din_q_a[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (done_cyc_a.size() !== 1 || (done_cyc_a.size() == 1 && done_cyc_a[0] !== t + 9)) begin
      failures++;
      $display("FAIL basic_done: pulses=%0d first=%0d required 1 at %0d",
               done_cyc_a.size(), (done_cyc_a.size() > 0) ? done_cyc_a[0] : -1, t + 9);
    end
    checks++;
    if (bout_a !== 8'hA5) begin
      failures++;
      $display("FAIL basic_bit_out: got %h required a5", bout_a);
    end
    checks++;
    if (rdy_a !== 1'b1 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle: ready=%b busy=%b required 1/0", rdy_a, busy_a);
    end
  endtask

  task automatic test_readback();
    int t;
    logic [7:0] exp_first, exp_second;
`ifdef DAISYCHAIN_READBACK_EN
    exp_first = 8'hA5;
    exp_second = 8'h3C;
`else
    exp_first = 8'h00;
    exp_second = 8'h00;
`endif
    issue(1'b0, 8'h3C, t);
    repeat (10) @(negedge clk);
    checks++;
    if (rsp_done_a !== exp_first) begin
      failures++;
      $display("FAIL readback_first: got %h required %h", rsp_done_a, exp_first);
    end
    clear_logs();
    issue(1'b0, 8'hC3, t);
    repeat (10) @(negedge clk);
    checks++;
    if (rsp_done_a !== exp_second || rsp_a !== exp_second) begin
      failures++;
      $display("FAIL readback_second: at_done=%h held=%h required %h",
               rsp_done_a, rsp_a, exp_second);
    end
    checks++;
    if (bout_a !== 8'hC3) begin
      failures++;
      $display("FAIL readback_bit_out: got %h required c3", bout_a);
    end
  endtask

  task automatic test_back_to_back();
    int t, t2, n;
    clear_logs();
    n = 0;
    va = 1'b1;
    da = 8'hFF;
    while (rdy_a !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    t = cyc;
    @(negedge clk);
    da = 8'h00;
    n = 0;
    while (rdy_a !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    t2 = cyc;
    @(negedge clk);
    va = 1'b0;
    checks++;
    if (t2 !== t + 10) begin
      failures++;
      $display("FAIL b2b_second_accept: got cycle %0d required %0d", t2, t + 10);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (done_cyc_a.size() !== 2) begin
      failures++;
      $display("FAIL b2b_done_count: got %0d required 2", done_cyc_a.size());
    end
    checks++;
    if (bout_a !== 8'h00) begin
      failures++;
      $display("FAIL b2b_bit_out: got %h required 00", bout_a);
    end
    checks++;
    if (overlap !== 0) begin
      failures++;
      $display("FAIL enable_update_overlap: got %0d cycles required 0", overlap);
    end
  endtask

  task automatic test_slow_pacer();
    int t;
    clear_logs();
    issue(1'b1, 8'h81, t);
    repeat (27) @(negedge clk);
    checks++;
    if (en_cyc_b.size() !== 8) begin
      failures++;
      $display("FAIL pacer_strobes: got %0d required 8", en_cyc_b.size());
    end
    if (en_cyc_b.size() == 8) begin
      checks++;
      if (en_cyc_b[0] !== t + 3 || en_cyc_b[1] !== t + 6 || en_cyc_b[7] !== t + 24) begin
        failures++;
        $display("FAIL pacer_strobe_cycles: got %0d,%0d,%0d required %0d,%0d,%0d",
                 en_cyc_b[0], en_cyc_b[1], en_cyc_b[7], t + 3, t + 6, t + 24);
      end
    end
    checks++;
    if (done_cyc_b.size() !== 1 || (done_cyc_b.size() == 1 && done_cyc_b[0] !== t + 25)) begin
      failures++;
      $display("FAIL pacer_done: pulses=%0d first=%0d required 1 at %0d",
               done_cyc_b.size(), (done_cyc_b.size() > 0) ? done_cyc_b[0] : -1, t + 25);
    end
    checks++;
    if (pack_bits(1'b1) !== 8'h81 || bout_b !== 8'h81) begin
      failures++;
      $display("FAIL pacer_data: serial=%h bit_out=%h required 81", pack_bits(1'b1), bout_b);
    end
  endtask

  task automatic test_abort();
    int t;
    issue(1'b0, 8'h55, t);
    repeat (10) @(negedge clk);
    clear_logs();
    issue(1'b0, 8'h0F, t);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({rdy_a, busy_a, done_a, din_a, en_a, upd_a} !== 6'b0 || rsp_a !== 8'h00) begin
      failures++;
      $display("FAIL abort_outputs: got %b rsp=%h required 000000/00",
               {rdy_a, busy_a, done_a, din_a, en_a, upd_a}, rsp_a);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (en_cyc_a.size() !== 4 || done_cyc_a.size() !== 0) begin
      failures++;
      $display("FAIL abort_activity: strobes=%0d dones=%0d required 4/0",
               en_cyc_a.size(), done_cyc_a.size());
    end
    checks++;
    if (bout_a !== 8'h55) begin
      failures++;
      $display("FAIL abort_bit_out: got %h required 55", bout_a);
    end
    checks++;
    if (rdy_a !== 1'b1 || st_a !== IDLE) begin
      failures++;
      $display("FAIL abort_ready: ready=%b state=%0d required 1/IDLE", rdy_a, st_a);
    end
  endtask

  task automatic test_busy_ignore();
    int t;
    clear_logs();
    issue(1'b0, 8'h96, t);
    repeat (2) @(negedge clk);
    va = 1'b1;
    da = 8'hEE;
    @(negedge clk);
    va = 1'b0;
    da = 8'h00;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cyc_a.size() !== 1 || en_cyc_a.size() !== 8) begin
      failures++;
      $display("FAIL busy_ignore_count: dones=%0d strobes=%0d required 1/8",
               done_cyc_a.size(), en_cyc_a.size());
    end
    checks++;
    if (bout_a !== 8'h96 || pack_bits(1'b0) !== 8'h96) begin
      failures++;
      $display("FAIL busy_ignore_data: bit_out=%h serial=%h required 96",
               bout_a, pack_bits(1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_readback();
    test_back_to_back();
    test_slow_pacer();
    test_abort();
    test_busy_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
